// File: rtl/scl_pkg.sv
// Shared definitions for the small-comb-logic result word: field positions,
// field widths and the packed result-word layout.
package scl_pkg;

    localparam int unsigned SCL_RES_W   = 8;

    localparam int unsigned SCL_F_POS   = 0;
    localparam int unsigned SCL_INV_POS = 1;
    localparam int unsigned SCL_XOR_POS = 2;
    localparam int unsigned SCL_SUM_POS = 4;
    localparam int unsigned SCL_AND_POS = 6;
    localparam int unsigned SCL_OR_POS  = 7;

    localparam int unsigned SCL_XOR_W   = 2;
    localparam int unsigned SCL_SUM_W   = 2;

    // Result word, MSB to LSB: or, and, sum[1:0], xor[1:0], inv, f
    typedef struct packed {
        logic                 or_f;
        logic                 and_f;
        logic [SCL_SUM_W-1:0] sum;
        logic [SCL_XOR_W-1:0] xor_f;
        logic                 inv;
        logic                 f;
    } scl_res_t;

endpackage

// File: rtl/scl_res_stats_sv.sv
// Saturating statistics accumulators for accepted result words:
// running sum of the 'sum' field and count of words with 'and' set.
// Clear has priority over a simultaneous push.
module scl_res_stats_sv
    import scl_pkg::*;
#(
    parameter int unsigned ACC_W = 12
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_push,
    input  logic                 i_clr,
    input  logic [SCL_SUM_W-1:0] i_sum,
    input  logic                 i_and,
    output logic [ACC_W-1:0]     o_sum_acc,
    output logic [ACC_W-1:0]     o_and_cnt
);

    localparam int unsigned EXT_W = ACC_W + 1;

    logic [ACC_W-1:0] r_sum_acc;
    logic [ACC_W-1:0] r_and_cnt;
    logic [EXT_W-1:0] w_sum_ext;
    logic [ACC_W-1:0] w_sum_nxt;
    logic [ACC_W-1:0] w_and_nxt;

    // Next accumulator values, clamped at all-ones instead of wrapping
    assign w_sum_ext = {1'b0, r_sum_acc} + EXT_W'(i_sum);
    assign w_sum_nxt = w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
    assign w_and_nxt = (&r_and_cnt) ? r_and_cnt : r_and_cnt + ACC_W'(i_and);

    // Accumulator registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sum_acc <= '0;
            r_and_cnt <= '0;
        end else if (i_clr) begin
            r_sum_acc <= '0;
            r_and_cnt <= '0;
        end else if (i_push) begin
            r_sum_acc <= w_sum_nxt;
            r_and_cnt <= w_and_nxt;
        end
    end

    assign o_sum_acc = r_sum_acc;
    assign o_and_cnt = r_and_cnt;

endmodule

// File: rtl/scl_res_fifo_sv.sv
// First-word-fall-through buffer for small-comb-logic result words with
// valid/ready on both sides. Ready/valid/level come from registered
// occupancy only. Statistics are built only when SCL_RES_STATS_EN is
// defined; otherwise sum_acc/and_cnt read 0 and stat_clr is ignored.
module scl_res_fifo_sv
    import scl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ACC_W = 12
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [SCL_RES_W-1:0]   in_data,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic [SCL_RES_W-1:0]   out_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   stat_clr,
    output logic [ACC_W-1:0]       sum_acc,
    output logic [ACC_W-1:0]       and_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    scl_res_t             r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;

    scl_res_t             w_in;
    logic [SCL_RES_W-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // Handshake decode from registered occupancy only
    assign w_in    = scl_res_t'(in_data);
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = in_vld && !w_full;
    assign w_pop   = out_rdy && !w_empty;

    assign in_rdy  = !w_full;
    assign out_vld = !w_empty;
    assign level   = r_level;

    // Head word; forced to zero while empty since storage is not reset
    assign w_head   = r_mem[r_rd_ptr];
    assign out_data = w_empty ? '0 : w_head;

    // Storage write; contents carry no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef SCL_RES_STATS_EN
    scl_res_stats_sv #(
        .ACC_W     (ACC_W)
    ) u_stats (
        .clk       (clk),
        .resetn    (resetn),
        .i_push    (w_push),
        .i_clr     (stat_clr),
        .i_sum     (w_in.sum),
        .i_and     (w_in.and_f),
        .o_sum_acc (sum_acc),
        .o_and_cnt (and_cnt)
    );
`else
    logic w_unused_stat_clr;

    assign w_unused_stat_clr = stat_clr;
    assign sum_acc           = '0;
    assign and_cnt           = '0;
`endif

endmodule

// File: tb/tb_scl_res_fifo_sv.sv
// Self-checking bench for scl_res_fifo_sv (DEPTH=4, ACC_W=4).
// A queue-based reference model is compared against the DUT on every
// falling edge; directed sections add hand-computed literal expectations.
// Statistics expectations follow SCL_RES_STATS_EN (zero when undefined).
module tb_scl_res_fifo_sv;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ACC_W = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int          SAT   = (1 << ACC_W) - 1;
`ifdef SCL_RES_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetn;
    logic [7:0]       in_data;
    logic             in_vld;
    logic             in_rdy;
    logic [7:0]       out_data;
    logic             out_vld;
    logic             out_rdy;
    logic [LVL_W-1:0] level;
    logic             stat_clr;
    logic [ACC_W-1:0] sum_acc;
    logic [ACC_W-1:0] and_cnt;

    int n_pass  = 0;
    int n_total = 0;

    scl_res_fifo_sv #(
        .DEPTH    (DEPTH),
        .ACC_W    (ACC_W)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .level    (level),
        .stat_clr (stat_clr),
        .sum_acc  (sum_acc),
        .and_cnt  (and_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Reference model: contents as a queue, statistics as saturating ints
    logic [7:0] m_q[$];
    int         m_sum;
    int         m_and;

    always @(posedge clk or negedge resetn) begin : model
        bit push, pop;
        if (!resetn) begin
            m_q.delete();
            m_sum = 0;
            m_and = 0;
        end else begin
            push = in_vld && (m_q.size() < DEPTH);
            pop  = out_rdy && (m_q.size() > 0);
            if (STATS) begin
                if (stat_clr) begin
                    m_sum = 0;
                    m_and = 0;
                end else if (push) begin
                    m_sum = m_sum + int'(in_data[5:4]);
                    if (m_sum > SAT) m_sum = SAT;
                    m_and = m_and + int'(in_data[6]);
                    if (m_and > SAT) m_and = SAT;
                end
            end
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(in_data);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("cyc_level",   level,   m_q.size());
        chk("cyc_out_vld", out_vld, int'(m_q.size() != 0));
        chk("cyc_in_rdy",  in_rdy,  int'(m_q.size() != DEPTH));
        chk("cyc_out_data", out_data, (m_q.size() != 0) ? int'(m_q[0]) : 0);
        chk("cyc_sum_acc", sum_acc, m_sum);
        chk("cyc_and_cnt", and_cnt, m_and);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] fill [4];

    initial begin
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
        resetn = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; stat_clr = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_level",   level,   0);
        chk("rst_in_rdy",  in_rdy,  1);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sum_acc", sum_acc, 0);
        chk("rst_and_cnt", and_cnt, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Fill with consumer stalled, then offer a fifth word
        for (int i = 0; i < 4; i++) begin
            in_vld = 1'b1; in_data = fill[i];
            @(negedge clk);
        end
        chk("full_level",  level,    4);
        chk("full_in_rdy", in_rdy,   0);
        chk("full_head",   out_data, 8'h11);
        in_data = 8'h55;
        repeat (2) @(negedge clk);
        chk("full_reject_level", level,    4);
        chk("full_reject_head",  out_data, 8'h11);
        in_vld = 1'b0;

        // Drain in order
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_vld",  out_vld,  1);
            chk("drain_data", out_data, fill[i]);
            @(negedge clk);
        end
        chk("drain_empty_vld", out_vld, 0);
        chk("drain_empty_lvl", level,   0);
        out_rdy = 1'b0;
        // 11,22,33,44 accepted: sum fields 1+2+3+0, one word with and set
        chk("fill_sum_acc", sum_acc, STATS ? 6 : 0);
        chk("fill_and_cnt", and_cnt, STATS ? 1 : 0);

        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("clr_sum_acc", sum_acc, 0);

        // Three FF pushes, then a fourth together with clear
        out_rdy = 1'b1;
        in_vld = 1'b1; in_data = 8'hFF;
        repeat (3) @(negedge clk);
        chk("ff3_sum_acc", sum_acc, STATS ? 9 : 0);
        chk("ff3_and_cnt", and_cnt, STATS ? 3 : 0);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("clrpush_sum_acc", sum_acc, 0);
        chk("clrpush_and_cnt", and_cnt, 0);

        // Saturation: 6 x sum=3 with a 4-bit accumulator
        in_data = 8'h30;
        repeat (6) @(negedge clk);
        in_vld = 1'b0;
        chk("sat_sum_acc", sum_acc, STATS ? 15 : 0);
        chk("sat_and_cnt", and_cnt, 0);
        @(negedge clk);
        chk("sat_drained", level, 0);
        out_rdy = 1'b0;

        // Simultaneous push/pop at level 2 across pointer wrap
        in_vld = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_data = 8'hA0 + 8'(k);
            @(negedge clk);
        end
        chk("pp_start_level", level, 2);
        out_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = 8'hA2 + 8'(k);
            @(negedge clk);
            chk("pp_level", level, 2);
            chk("pp_head",  out_data, 8'hA0 + k + 1);
        end
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
        chk("pp_drained", level, 0);
        out_rdy = 1'b0;

        // Asynchronous reset mid-stream at level 3
        in_vld = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_data = 8'(k);
            @(negedge clk);
        end
        in_vld = 1'b0;
        chk("pre_rst_level", level, 3);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_level",   level,    0);
        chk("mid_rst_out_vld", out_vld,  0);
        chk("mid_rst_in_rdy",  in_rdy,   1);
        chk("mid_rst_sum_acc", sum_acc,  0);
        chk("mid_rst_and_cnt", and_cnt,  0);
        chk("mid_rst_data",    out_data, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Random traffic against the model
        for (int n = 0; n < 1000; n++) begin
            in_vld   = 1'($urandom_range(0, 1));
            out_rdy  = 1'($urandom_range(0, 1));
            stat_clr = ($urandom_range(0, 49) == 0);
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_vld = 1'b0; out_rdy = 1'b0; stat_clr = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
